// File: rtl/m8088_bus_bridge_pkg.sv
// Shared types and constants for the m8088 bus bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the bridge FSM state enum, the bus cycle-type codes and the
// address/data widths of the 8088 pin interface.
package m8088_bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDLY,
        REQ,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        MEMRD,
        MEMWR,
        IORD,
        IOWR,
        INTA
    } cyc_t;

    // Cycles that return data to the CPU on completion.
    function automatic logic cyc_is_read(input cyc_t c);
        return (c == MEMRD) || (c == IORD) || (c == INTA);
    endfunction

endpackage

// File: rtl/m8088_bus_bridge_if.sv
// CPU-pin and system-request signal bundle for the m8088 bus bridge.
// Latency: n/a (wires only).
// Backpressure: READY toward the CPU, sys_req/sys_ack toward the system.
//
// slave  : the bridge view (CPU pins and system response in, READY/request out).
// master : the environment view (CPU plus system responder).
interface m8088_bus_bridge_if;
    import m8088_bus_pkg::*;

    // CPU side
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_dout;
    logic [DATA_W-1:0] cpu_din;
    logic              ALE;
    logic              RD_n;
    logic              WR_n;
    logic              IOM;
    logic              INTA_n;
    logic              READY;

    // System side
    logic              sys_req;
    logic              sys_we;
    logic              sys_io;
    logic              sys_inta;
    logic [ADDR_W-1:0] sys_addr;
    logic [DATA_W-1:0] sys_wdata;
    logic [DATA_W-1:0] sys_rdata;
    logic              sys_ack;
    logic              sys_timeout;

    modport slave (
        input  cpu_addr, cpu_dout, ALE, RD_n, WR_n, IOM, INTA_n, sys_rdata, sys_ack,
        output cpu_din, READY, sys_req, sys_we, sys_io, sys_inta, sys_addr, sys_wdata,
               sys_timeout
    );

    modport master (
        output cpu_addr, cpu_dout, ALE, RD_n, WR_n, IOM, INTA_n, sys_rdata, sys_ack,
        input  cpu_din, READY, sys_req, sys_we, sys_io, sys_inta, sys_addr, sys_wdata,
               sys_timeout
    );

endinterface

// File: rtl/m8088_bus_bridge_timer.sv
// Down-counter shared by the post-ack wait and the request timeout.
// Latency: expire_o is registered state; load takes effect the next cycle.
// Backpressure: none; holds at zero until reloaded.
//
// Ports: CORE_CLK/RESET; load_i + load_val_i preset the count; en_i
// decrements it; expire_o is high while the count is zero.
module m8088_bus_bridge_timer #(
    parameter int CNT_W = 8
) (
    input  logic             CORE_CLK,
    input  logic             RESET,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CORE_CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/m8088_bus_bridge.sv
// Converts multiplexed 8088 bus cycles into one outstanding sys_req/sys_ack transaction.
// Latency: sys_req 1 cycle after a read/INTA strobe, 2 after WR_n; READY 1+MIN_WAIT after sys_ack.
// Backpressure: READY held low (CPU wait states) until the system acknowledges.
//
// Ports: CORE_CLK, RESET (sync, active high), bus (slave modport: CPU pins
// ALE/RD_n/WR_n/IOM/INTA_n/cpu_addr/cpu_dout in, cpu_din/READY out; system
// sys_req/sys_we/sys_io/sys_inta/sys_addr/sys_wdata out, sys_rdata/sys_ack in,
// sys_timeout out).
// Optional macro M8088_BUS_BRIDGE_TIMEOUT_EN: forced completion after
// TIMEOUT_CYCLES request cycles without sys_ack; otherwise sys_timeout is 0.
module m8088_bus_bridge
    import m8088_bus_pkg::*;
#(
    parameter int MIN_WAIT       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CORE_CLK,
    input  logic              RESET,
    m8088_bus_bridge_if.slave bus
);

    // One counter covers both uses, so size it for the larger.
    localparam int CNT_MAX = (MIN_WAIT > TIMEOUT_CYCLES) ? MIN_WAIT : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    // The counter expires while at zero, so preload one less than the cycle count.
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((MIN_WAIT > 0) ? MIN_WAIT - 1 : 0);
`ifdef M8088_BUS_BRIDGE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`endif

    state_t            state_q, state_d;
    cyc_t              cyc_q, cyc_d;
    logic              ale_q;
    logic              ready_q, ready_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              io_q, io_d;
    logic              inta_q, inta_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              abort_q, abort_d;
`ifdef M8088_BUS_BRIDGE_TIMEOUT_EN
    logic              tmo_q, tmo_d;
`endif

    logic              ale_fall;
    logic              strobes_idle;
    logic              discard;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_en;
    logic              tmr_expire;

    assign ale_fall     = ale_q & ~bus.ALE;
    assign strobes_idle = bus.RD_n & bus.WR_n & bus.INTA_n;
    // A strobe released while the request is outstanding discards its result.
    assign discard      = abort_q | strobes_idle;

    m8088_bus_bridge_timer #(.CNT_W(CNT_W)) u_timer (
        .CORE_CLK   (CORE_CLK),
        .RESET      (RESET),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        ready_d  = ready_q;
        req_d    = req_q;
        we_d     = we_q;
        io_d     = io_q;
        inta_d   = inta_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        din_d    = din_q;
        abort_d  = abort_q;
        tmr_load = 1'b0;
        tmr_val  = WAIT_LOAD;
        tmr_en   = 1'b0;
`ifdef M8088_BUS_BRIDGE_TIMEOUT_EN
        tmo_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (ale_fall) begin
                    addr_d  = bus.cpu_addr;
                    io_d    = ~bus.IOM;
                    ready_d = 1'b0;
                    state_d = ADDR;
                end
            end

            ADDR: begin
                if (!bus.INTA_n || !bus.RD_n) begin
                    we_d    = 1'b0;
                    inta_d  = ~bus.INTA_n;
                    req_d   = 1'b1;
                    abort_d = 1'b0;
                    if (!bus.INTA_n) begin
                        cyc_d = INTA;
                    end else begin
                        cyc_d = io_q ? IORD : MEMRD;
                    end
                    state_d = REQ;
`ifdef M8088_BUS_BRIDGE_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
`endif
                end else if (!bus.WR_n) begin
                    // Write data is only valid one cycle after WR_n falls.
                    state_d = WDLY;
                end else if (ale_fall) begin
                    addr_d = bus.cpu_addr;
                    io_d   = ~bus.IOM;
                end
            end

            WDLY: begin
                wdata_d = bus.cpu_dout;
                we_d    = 1'b1;
                inta_d  = 1'b0;
                req_d   = 1'b1;
                abort_d = 1'b0;
                cyc_d   = io_q ? IOWR : MEMWR;
                state_d = REQ;
`ifdef M8088_BUS_BRIDGE_TIMEOUT_EN
                tmr_load = 1'b1;
                tmr_val  = TO_LOAD;
`endif
            end

            REQ: begin
                abort_d = discard;
                if (bus.sys_ack) begin
                    req_d = 1'b0;
                    if (cyc_is_read(cyc_q) && !discard) begin
                        din_d = bus.sys_rdata;
                    end
                    if (MIN_WAIT == 0) begin
                        state_d = DONE;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = WAIT_LOAD;
                        state_d  = WAIT;
                    end
                end
`ifdef M8088_BUS_BRIDGE_TIMEOUT_EN
                else if (tmr_expire) begin
                    req_d = 1'b0;
                    if (cyc_is_read(cyc_q) && !discard) begin
                        din_d = 8'hFF;
                    end
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmr_en = 1'b1;
                end
`endif
            end

            WAIT: begin
                if (tmr_expire) begin
                    state_d = DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            DONE: begin
                ready_d = 1'b1;
                if (strobes_idle) begin
                    // A new address phase already under way starts the next cycle directly.
                    if (ale_fall) begin
                        addr_d  = bus.cpu_addr;
                        io_d    = ~bus.IOM;
                        ready_d = 1'b0;
                        state_d = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CORE_CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cyc_q   <= MEMRD;
            ale_q   <= 1'b0;
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            inta_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            din_q   <= 8'hFF;
            abort_q <= 1'b0;
`ifdef M8088_BUS_BRIDGE_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ale_q   <= bus.ALE;
            ready_q <= ready_d;
            req_q   <= req_d;
            we_q    <= we_d;
            io_q    <= io_d;
            inta_q  <= inta_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            din_q   <= din_d;
            abort_q <= abort_d;
`ifdef M8088_BUS_BRIDGE_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.READY     = ready_q;
    assign bus.sys_req   = req_q;
    assign bus.sys_we    = we_q;
    assign bus.sys_io    = io_q;
    assign bus.sys_inta  = inta_q;
    assign bus.sys_addr  = addr_q;
    assign bus.sys_wdata = wdata_q;
    assign bus.cpu_din   = din_q;
`ifdef M8088_BUS_BRIDGE_TIMEOUT_EN
    assign bus.sys_timeout = tmo_q;
`else
    assign bus.sys_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_m8088_bus_bridge.sv
// Testbench for m8088_bus_bridge: two instances (MIN_WAIT=0 and MIN_WAIT=2).
// Stimulus is muxed to one instance at a time; a transaction-level model
// predicts request fields, latencies and the CPU read-data register.
module tb_m8088_bus_bridge;
    import m8088_bus_pkg::*;

    localparam int TO_CYC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel_b;
    logic        ale, rd_n, wr_n, iom, inta_n, ack;
    logic [19:0] addr;
    logic [7:0]  dout, rdata;

    m8088_bus_bridge_if bus_a ();
    m8088_bus_bridge_if bus_b ();

    m8088_bus_bridge #(.MIN_WAIT(0), .TIMEOUT_CYCLES(TO_CYC)) dut_a (
        .CORE_CLK (clk),
        .RESET    (rst),
        .bus      (bus_a)
    );

    m8088_bus_bridge #(.MIN_WAIT(2), .TIMEOUT_CYCLES(TO_CYC)) dut_b (
        .CORE_CLK (clk),
        .RESET    (rst),
        .bus      (bus_b)
    );

    // The unselected instance sees an idle bus.
    assign bus_a.ALE       = sel_b ? 1'b0 : ale;
    assign bus_a.RD_n      = sel_b ? 1'b1 : rd_n;
    assign bus_a.WR_n      = sel_b ? 1'b1 : wr_n;
    assign bus_a.INTA_n    = sel_b ? 1'b1 : inta_n;
    assign bus_a.sys_ack   = sel_b ? 1'b0 : ack;
    assign bus_a.IOM       = iom;
    assign bus_a.cpu_addr  = addr;
    assign bus_a.cpu_dout  = dout;
    assign bus_a.sys_rdata = rdata;
    assign bus_b.ALE       = sel_b ? ale    : 1'b0;
    assign bus_b.RD_n      = sel_b ? rd_n   : 1'b1;
    assign bus_b.WR_n      = sel_b ? wr_n   : 1'b1;
    assign bus_b.INTA_n    = sel_b ? inta_n : 1'b1;
    assign bus_b.sys_ack   = sel_b ? ack    : 1'b0;
    assign bus_b.IOM       = iom;
    assign bus_b.cpu_addr  = addr;
    assign bus_b.cpu_dout  = dout;
    assign bus_b.sys_rdata = rdata;

    wire        obs_ready = sel_b ? bus_b.READY       : bus_a.READY;
    wire        obs_req   = sel_b ? bus_b.sys_req     : bus_a.sys_req;
    wire        obs_we    = sel_b ? bus_b.sys_we      : bus_a.sys_we;
    wire        obs_io    = sel_b ? bus_b.sys_io      : bus_a.sys_io;
    wire        obs_inta  = sel_b ? bus_b.sys_inta    : bus_a.sys_inta;
    wire        obs_tmo   = sel_b ? bus_b.sys_timeout : bus_a.sys_timeout;
    wire [19:0] obs_addr  = sel_b ? bus_b.sys_addr    : bus_a.sys_addr;
    wire [7:0]  obs_wdata = sel_b ? bus_b.sys_wdata   : bus_a.sys_wdata;
    wire [7:0]  obs_din   = sel_b ? bus_b.cpu_din     : bus_a.cpu_din;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_din = 8'hFF;   // model of the CPU read-data register

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_strobes();
        rd_n = 1'b1; wr_n = 1'b1; inta_n = 1'b1;
    endtask

    // One complete CPU bus cycle plus system responder. Ends in the
    // completion phase with the strobe still asserted (unless aborted).
    task automatic cpu_cycle(input cyc_t kind, input logic [19:0] a, input logic [7:0] wd,
                             input int lat, input logic [7:0] rd, input bit abort, input int gap);
        bit is_wr   = (kind == MEMWR) || (kind == IOWR);
        bit is_inta = (kind == INTA);
        bit is_io   = (kind == IORD) || (kind == IOWR) || (kind == INTA);
        int mw      = sel_b ? 2 : 0;
        int n;
        for (int i = 0; i < gap; i++) begin
            release_strobes();
            tick();
        end
        addr = a; iom = ~is_io; ale = 1'b1;
        tick();
        ale = 1'b0; release_strobes();
        tick();
        chk("ready_low_after_ale", obs_ready, 0);
        addr = 20'($urandom);
        if (is_wr) begin
            wr_n = 1'b0; dout = 8'($urandom);
            tick();
            chk("req_wr_first_cycle", obs_req, 0);
            dout = wd;
            tick();
        end else begin
            if (is_inta) inta_n = 1'b0; else rd_n = 1'b0;
            tick();
        end
        chk("req_rise", obs_req, 1);
        chk("sys_addr", obs_addr, a);
        chk("sys_io", obs_io, is_io);
        chk("sys_we", obs_we, is_wr);
        chk("sys_inta", obs_inta, is_inta);
        if (is_wr) chk("sys_wdata", obs_wdata, wd);
        for (int i = 1; i < lat; i++) begin
            if (abort && i == 1) release_strobes();
            tick();
        end
        chk("req_held", obs_req, 1);
        chk("ready_held_low", obs_ready, 0);
        ack = 1'b1; rdata = rd;
        tick();
        ack = 1'b0; rdata = 8'($urandom);
        chk("req_drop", obs_req, 0);
        n = 0;
        while (obs_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("ready_delay", n, 1 + mw);
        if (!is_wr && !abort) m_din = rd;
        chk("cpu_din", obs_din, m_din);
        chk("timeout_quiet", obs_tmo, 0);
    endtask

    task automatic start_read(input logic [19:0] a);
        release_strobes();
        tick();
        addr = a; iom = 1'b1; ale = 1'b1;
        tick();
        ale = 1'b0;
        tick();
        rd_n = 1'b0;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        bit ab;
        sel_b = 1'b0; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; inta_n = 1'b1;
        iom = 1'b1; ack = 1'b0; addr = '0; dout = '0; rdata = '0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_ready", obs_ready, 1);
        chk("rst_req", obs_req, 0);
        chk("rst_we", obs_we, 0);
        chk("rst_io", obs_io, 0);
        chk("rst_inta", obs_inta, 0);
        chk("rst_addr", obs_addr, 0);
        chk("rst_wdata", obs_wdata, 0);
        chk("rst_din", obs_din, 8'hFF);
        chk("rst_tmo", obs_tmo, 0);
        rst = 1'b0;
        tick();

        // Directed cycles
        cpu_cycle(MEMRD, 20'hF0010, 8'h00, 3, 8'h5A, 1'b0, 1);
        cpu_cycle(IOWR,  20'h00040, 8'hC3, 2, 8'h11, 1'b0, 2);
        cpu_cycle(INTA,  20'h00000, 8'h00, 1, 8'h08, 1'b0, 1);
        cpu_cycle(INTA,  20'h00000, 8'h00, 1, 8'h21, 1'b0, 0);
        cpu_cycle(MEMRD, 20'h12345, 8'h00, 3, 8'h99, 1'b1, 0);

        // Randomized cycles on the MIN_WAIT=0 instance
        for (int t = 0; t < 40; t++) begin
            lat = int'($urandom_range(1, 6));
            ab  = ($urandom_range(0, 5) == 0);
            if (ab && lat < 2) lat = 2;
            cpu_cycle(cyc_t'($urandom_range(0, 4)), 20'($urandom), 8'($urandom), lat,
                      8'($urandom), ab, int'($urandom_range(0, 2)));
        end

        // Reset while a request is outstanding, then a stray ack
        start_read(20'hABCDE);
        chk("pre_reset_req", obs_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_din = 8'hFF;
        chk("reset_req_drop", obs_req, 0);
        chk("reset_ready", obs_ready, 1);
        chk("reset_addr", obs_addr, 0);
        chk("reset_din", obs_din, 8'hFF);
        release_strobes();
        ack = 1'b1; rdata = 8'h66;
        tick();
        ack = 1'b0;
        tick();
        chk("stray_ack_req", obs_req, 0);
        chk("stray_ack_ready", obs_ready, 1);
        chk("stray_ack_din", obs_din, 8'hFF);
        cpu_cycle(MEMRD, 20'h00777, 8'h00, 2, 8'h3C, 1'b0, 1);

`ifdef M8088_BUS_BRIDGE_TIMEOUT_EN
        start_read(20'h0BEEF);
        n = 0;
        while (obs_tmo !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("timeout_cycle", n, TO_CYC);
        m_din = 8'hFF;
        chk("timeout_req", obs_req, 0);
        chk("timeout_din", obs_din, m_din);
        tick();
        chk("timeout_pulse_once", obs_tmo, 0);
        chk("timeout_ready", obs_ready, 1);
`else
        start_read(20'h0BEEF);
        repeat (40) tick();
        chk("no_timeout_req", obs_req, 1);
        chk("no_timeout_ready", obs_ready, 0);
        chk("no_timeout_tmo", obs_tmo, 0);
        ack = 1'b1; rdata = 8'h77;
        tick();
        ack = 1'b0;
        n = 0;
        while (obs_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("late_ack_ready", n, 1);
        m_din = 8'h77;
        chk("late_ack_din", obs_din, m_din);
`endif
        release_strobes();
        tick(); tick();

        // MIN_WAIT=2 instance
        sel_b = 1'b1;
        m_din = 8'hFF;
        tick();
        cpu_cycle(MEMRD, 20'h54321, 8'h00, 1, 8'hE7, 1'b0, 1);
        for (int t = 0; t < 10; t++) begin
            lat = int'($urandom_range(1, 5));
            ab  = ($urandom_range(0, 5) == 0);
            if (ab && lat < 2) lat = 2;
            cpu_cycle(cyc_t'($urandom_range(0, 4)), 20'($urandom), 8'($urandom), lat,
                      8'($urandom), ab, int'($urandom_range(0, 2)));
        end
        release_strobes();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m8088_bus_bridge.md
Name: m8088_bus_bridge

Overview:
- Sits directly downstream of the m8088 CPU pins and converts its multiplexed 8088-style bus cycles into a single-outstanding request/acknowledge transaction on the system side.
- Pin signals consumed: ALE, RD_n, WR_n, IOM, INTA_n, addr, dout.
- Returns read data on din and generates the CPU READY input, inserting wait states until the system acknowledges.

Parameters:
- MIN_WAIT, 0: extra CORE_CLK cycles READY is held low after sys_ack before completion.
- TIMEOUT_CYCLES, 255: cycles without sys_ack before forced completion. Used only with the optional feature.

Ports:
- CORE_CLK  in  1  single clock for all logic.
- RESET  in  1  synchronous, active-high reset.
- cpu_addr  in  20  CPU latched address; stable from the first cycle ALE is low.
- cpu_dout  in  8  CPU write data; valid from the cycle after WR_n falls.
- cpu_din  out  8  read data to the CPU.
- ALE  in  1  CPU address latch enable.
- RD_n  in  1  CPU read strobe, active low.
- WR_n  in  1  CPU write strobe, active low.
- IOM  in  1  1 = memory cycle, 0 = I/O cycle.
- INTA_n  in  1  interrupt acknowledge strobe, active low.
- READY  out  1  CPU wait control; 0 inserts wait states.
- sys_req  out  1  system request; held until sys_ack.
- sys_we  out  1  1 = write.
- sys_io  out  1  1 = I/O space.
- sys_inta  out  1  1 = interrupt-acknowledge read.
- sys_addr  out  20  request address.
- sys_wdata  out  8  request write data.
- sys_rdata  in  8  system read data, valid with sys_ack.
- sys_ack  in  1  single-cycle completion pulse.
- sys_timeout  out  1  one-cycle pulse on forced completion. Optional feature only; tied 0 otherwise.

Behaviour:
- Reset values: READY=1, sys_req=0, sys_we=0, sys_io=0, sys_inta=0, sys_addr=0, sys_wdata=0, cpu_din=8'hFF, sys_timeout=0. Reset mid-cycle drops sys_req the next cycle and returns to IDLE. Any later stray sys_ack is ignored.
- Edge detect: ALE is registered as ale_q. An ALE falling edge is ale_q=1 and ALE=0.
- IDLE:
  - On ALE falling edge: latch sys_addr<=cpu_addr and sys_io<=~IOM, drive READY<=0, go to ADDR.
  - All other inputs are ignored, including sys_ack.
- ADDR: wait for a strobe.
  - RD_n=0: sys_we<=0, sys_inta<=0, sys_req<=1, go to REQ.
  - INTA_n=0: same as RD_n, but sys_inta<=1.
  - WR_n=0: go to WDLY.
  - If more than one strobe is low, priority is INTA_n > RD_n > WR_n.
  - A new ALE falling edge in ADDR re-latches the address; no request has been issued yet.
- WDLY: one cycle. sys_wdata<=cpu_dout, sys_we<=1, sys_req<=1, go to REQ.
- REQ:
  - sys_req stays 1 and all sys_* outputs are frozen.
  - On sys_ack: sys_req<=0; for a read, cpu_din<=sys_rdata. Go to WAIT, or straight to DONE if MIN_WAIT=0.
  - Minimum latency, first strobe sample to sys_req: reads 1 cycle, writes 2 cycles.
- WAIT: count MIN_WAIT cycles, then go to DONE.
- DONE:
  - READY<=1 and cpu_din is held.
  - When RD_n=1, WR_n=1 and INTA_n=1 are all sampled, go to IDLE.
  - An ALE falling edge seen in DONE with strobes already high is handled as in IDLE, giving back-to-back cycles with no lost cycle.
- Strobe released before ack (abort): the request still completes on the system side; the result is discarded, and the FSM passes through DONE and then to IDLE.
- sys_ack arriving in the same cycle as sys_req first rises is legal: ack is sampled from the cycle after sys_req=1, so the minimum system latency is 1.
- cpu_din keeps the last read value between cycles and is not cleared.

Optional Feature:
- Macro: M8088_BUS_BRIDGE_TIMEOUT_EN.
- With the macro: a counter clears on entry to REQ and increments each REQ cycle. On reaching TIMEOUT_CYCLES without sys_ack:
  - sys_req<=0;
  - reads return cpu_din<=8'hFF;
  - sys_timeout pulses for 1 cycle;
  - the FSM goes to DONE.
  - A sys_ack in that same cycle wins: normal completion, no pulse.
- Without the macro: REQ waits indefinitely, no counter logic is generated, and sys_timeout is tied 0.

Decomposition:
- Package m8088_bus_pkg holds:
  - the state enum (IDLE, ADDR, WDLY, REQ, WAIT, DONE);
  - the cycle-type constants (MEMRD, MEMWR, IORD, IOWR, INTA);
  - the 20-bit address and 8-bit data width constants.
- One sub-module, m8088_bus_bridge_timer, covers both the MIN_WAIT and timeout counting: load, enable, expire.

Test Plan:
- Memory read at 20'hF0010, sys_ack 3 cycles after sys_req with sys_rdata=8'h5A:
  - sys_addr=F0010, sys_io=0, sys_we=0;
  - READY low from the cycle after the ALE fall until the ack cycle plus 1;
  - cpu_din=5A.
- I/O write to 20'h00040 of 8'hC3:
  - sys_io=1, sys_we=1, sys_wdata=C3;
  - sys_req rises 2 cycles after WR_n falls.
- INTA cycle with sys_rdata=8'h08:
  - sys_inta=1, cpu_din=08;
  - back-to-back second INTA completes with no idle cycle lost.
- MIN_WAIT=2, ack latency 1: READY rises exactly 3 cycles after sys_ack.
- RESET asserted while in REQ, then a stray sys_ack: sys_req=0 the next cycle, READY=1, state IDLE; the stray ack has no effect.
- With the macro defined, TIMEOUT_CYCLES=16, no ack on a read: sys_timeout pulses once at cycle 16, cpu_din=FF, READY=1.
